// File: rtl/axil_gpio.sv
// axil_gpio: AXI4-Lite slave GPIO with per-bit direction, atomic set/clear
// and edge-triggered interrupts.
// Build option: define GPIO_IRQ_EN to implement IRQ_EN, IRQ_RISE, IRQ_STAT,
// the edge logic and irq. Without it those offsets read 0 and irq is 0.
module axil_gpio #(
    parameter int unsigned GPIO_WIDTH = 32,
    parameter logic [31:0] BASE_MASK  = 32'h0000_001F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [31:0]           s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam logic [31:0] OFF_OUT      = 32'h00;
    localparam logic [31:0] OFF_DIR      = 32'h04;
    localparam logic [31:0] OFF_IN       = 32'h08;
    localparam logic [31:0] OFF_SET      = 32'h0C;
    localparam logic [31:0] OFF_CLR      = 32'h10;
    localparam logic [31:0] OFF_IRQ_EN   = 32'h14;
    localparam logic [31:0] OFF_IRQ_RISE = 32'h18;
    localparam logic [31:0] OFF_IRQ_STAT = 32'h1C;

    logic [31:0]           wr_off;
    logic [31:0]           rd_off;
    logic [31:0]           strb_bits;
    logic [31:0]           wmasked;
    logic [GPIO_WIDTH-1:0] wbits;
    logic [GPIO_WIDTH-1:0] bmask;
    logic                  wr_go;
    logic                  rd_go;
    logic                  bvalid_q;
    logic                  rvalid_q;
    logic [31:0]           rdata_q;
    logic [31:0]           rd_word;

    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] out_d;
    logic [GPIO_WIDTH-1:0] dir_q;
    logic [GPIO_WIDTH-1:0] dir_d;
    logic [GPIO_WIDTH-1:0] meta_q;
    logic [GPIO_WIDTH-1:0] sync_q;

    logic                  unused_hi;

    assign wr_off = s_awaddr & BASE_MASK;
    assign rd_off = s_araddr & BASE_MASK;

    // expand byte strobes into a per-bit write mask
    always_comb begin
        strb_bits = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            strb_bits[8*b +: 8] = {8{s_wstrb[b]}};
        end
    end

    assign wmasked   = s_wdata & strb_bits;
    assign wbits     = wmasked[GPIO_WIDTH-1:0];
    assign bmask     = strb_bits[GPIO_WIDTH-1:0];
    assign unused_hi = ^{wmasked, strb_bits};

    // handshakes: a write needs both channels at once and no pending response
    assign wr_go     = s_awvalid & s_wvalid & ~bvalid_q;
    assign s_awready = wr_go;
    assign s_wready  = wr_go;
    assign rd_go     = s_arvalid & ~rvalid_q;
    assign s_arready = ~rvalid_q;

    assign s_bvalid = bvalid_q;
    assign s_bresp  = 2'b00;
    assign s_rvalid = rvalid_q;
    assign s_rdata  = rdata_q;
    assign s_rresp  = 2'b00;

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

    // next OUT / DIR values from RW, SET and CLR writes
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (wr_go) begin
            case (wr_off)
                OFF_OUT: out_d = (out_q & ~bmask) | wbits;
                OFF_DIR: dir_d = (dir_q & ~bmask) | wbits;
                OFF_SET: out_d = out_q | wbits;
                OFF_CLR: out_d = out_q & ~wbits;
                default: ;
            endcase
        end
    end

    // OUT and DIR registers feed the pins directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            dir_q <= '0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
        end
    end

    // two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= gpio_in;
            sync_q <= meta_q;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] en_q;
    logic [GPIO_WIDTH-1:0] en_d;
    logic [GPIO_WIDTH-1:0] rise_q;
    logic [GPIO_WIDTH-1:0] rise_d;
    logic [GPIO_WIDTH-1:0] stat_q;
    logic [GPIO_WIDTH-1:0] stat_d;
    logic [GPIO_WIDTH-1:0] w1c;
    logic [GPIO_WIDTH-1:0] edge_hit;
    logic                  irq_q;

    // Edges are judged on the value about to enter sync, so IRQ_STAT is
    // set on the same clock that IN shows the new level; a new edge
    // overrides a concurrent W1C of the same bit.
    always_comb begin
        edge_hit = (meta_q & ~sync_q & rise_q) | (~meta_q & sync_q & ~rise_q);
        en_d     = en_q;
        rise_d   = rise_q;
        w1c      = '0;
        if (wr_go) begin
            case (wr_off)
                OFF_IRQ_EN:   en_d   = (en_q & ~bmask) | wbits;
                OFF_IRQ_RISE: rise_d = (rise_q & ~bmask) | wbits;
                OFF_IRQ_STAT: w1c    = wbits;
                default: ;
            endcase
        end
        stat_d = (stat_q & ~w1c) | edge_hit;
    end

    // interrupt configuration, status and the registered irq line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= '0;
            rise_q <= '0;
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            rise_q <= rise_d;
            stat_q <= stat_d;
            irq_q  <= |(stat_q & en_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // read mux over the current (pre-write) register values
    always_comb begin
        rd_word = '0;
        case (rd_off)
            OFF_OUT:      rd_word = 32'(out_q);
            OFF_DIR:      rd_word = 32'(dir_q);
            OFF_IN:       rd_word = 32'(sync_q);
`ifdef GPIO_IRQ_EN
            OFF_IRQ_EN:   rd_word = 32'(en_q);
            OFF_IRQ_RISE: rd_word = 32'(rise_q);
            OFF_IRQ_STAT: rd_word = 32'(stat_q);
`endif
            default:      rd_word = '0;
        endcase
    end

    // write response: raised after acceptance, held until bready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_q <= 1'b0;
        end else if (bvalid_q) begin
            if (s_bready) begin
                bvalid_q <= 1'b0;
            end
        end else if (wr_go) begin
            bvalid_q <= 1'b1;
        end
    end

    // read data: captured on acceptance, held stable until rready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (rvalid_q) begin
            if (s_rready) begin
                rvalid_q <= 1'b0;
            end
        end else if (rd_go) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
        end
    end

endmodule
